// File: rtl/facto_bus_master_if.sv
// Host command/response channel and factorial-core slave bus bundled together.
// The master modport is the initiator side; slave is the host plus core side.
interface facto_bus_master_if;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [63:0]  cmd_operand;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [127:0] rsp_result;
    logic         rsp_timeout;
    logic         busy;
    logic         m_sel;
    logic         m_wr;
    logic [15:0]  m_addr;
    logic [63:0]  m_dout;
    logic [63:0]  m_din;
    logic         interrupt;

    modport master (
        input  cmd_valid, cmd_operand, rsp_ready, m_din, interrupt,
        output cmd_ready, rsp_valid, rsp_result, rsp_timeout, busy,
        output m_sel, m_wr, m_addr, m_dout
    );

    modport slave (
        output cmd_valid, cmd_operand, rsp_ready, m_din, interrupt,
        input  cmd_ready, rsp_valid, rsp_result, rsp_timeout, busy,
        input  m_sel, m_wr, m_addr, m_dout
    );
endinterface

// File: rtl/facto_bus_master.sv
// Bus initiator that runs one factorial job per host command on the core slave:
// program, wait for completion (irq or polling), read 128-bit result, clear.
module facto_bus_master #(
    parameter logic [15:0] ADDR_OPSTART  = 16'h0000,
    parameter logic [15:0] ADDR_OPCLEAR  = 16'h0008,
    parameter logic [15:0] ADDR_OPDONE   = 16'h0010,
    parameter logic [15:0] ADDR_INTREN   = 16'h0018,
    parameter logic [15:0] ADDR_OPERAND  = 16'h0020,
    parameter logic [15:0] ADDR_RESULT_H = 16'h0028,
    parameter logic [15:0] ADDR_RESULT_L = 16'h0030,
    parameter bit          USE_IRQ       = 1'b1,
    parameter int          POLL_GAP      = 4,
    parameter int          TIMEOUT       = 65535
) (
    input logic               clk,
    input logic               reset,
    facto_bus_master_if.master bus
);

    localparam logic [15:0] GAP = 16'(POLL_GAP);
    localparam logic [15:0] TMO = 16'(TIMEOUT);

    typedef enum logic [3:0] {
        S_IDLE, S_W_IEN, S_W_OPND, S_W_STRT, S_W_UNST, S_WAIT,
        S_R_HI, S_R_LO, S_W_CLR, S_W_UNCLR, S_RESP
    } state_t;

    state_t       state, state_n;
    logic [63:0]  operand;
    logic [127:0] result;
    logic         timeout_q;
    logic [15:0]  wcnt;
    logic [15:0]  gap, gap_n;
    logic         sel_q, sel_n;
    logic         wr_q, wr_n;
    logic [15:0]  addr_q, addr_n;
    logic [63:0]  dout_q, dout_n;
    logic         done, expired;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            operand   <= '0;
            result    <= '0;
            timeout_q <= 1'b0;
            wcnt      <= '0;
            gap       <= '0;
            sel_q     <= 1'b0;
            wr_q      <= 1'b0;
            addr_q    <= '0;
            dout_q    <= '0;
        end else begin
            state  <= state_n;
            sel_q  <= sel_n;
            wr_q   <= wr_n;
            addr_q <= addr_n;
            dout_q <= dout_n;
            gap    <= gap_n;
            wcnt   <= (state == S_WAIT) ? wcnt + 16'd1 : 16'd0;
            if (state == S_IDLE && bus.cmd_valid) begin
                operand   <= bus.cmd_operand;
                timeout_q <= 1'b0;
            end
            if (state == S_WAIT && !done && expired) begin
                timeout_q <= 1'b1;
                result    <= '0;
            end
            if (state == S_R_HI)
                result[127:64] <= bus.m_din;
            if (state == S_R_LO)
                result[63:0] <= bus.m_din;
        end
    end

    always_comb begin
        state_n = state;
        gap_n   = '0;
        done    = 1'b0;
        expired = 1'b0;
        unique case (state)
            S_IDLE:    if (bus.cmd_valid) state_n = S_W_IEN;
            S_W_IEN:   state_n = S_W_OPND;
            S_W_OPND:  state_n = S_W_STRT;
            S_W_STRT:  state_n = S_W_UNST;
            S_W_UNST:  state_n = S_WAIT;
            S_WAIT: begin
                gap_n   = (gap == GAP) ? 16'd0 : gap + 16'd1;
                done    = USE_IRQ ? bus.interrupt
                                  : (sel_q & bus.m_din[0]);
                expired = (wcnt == TMO);
                if (done)
                    state_n = S_R_HI;
                else if (expired)
                    state_n = S_W_CLR;
            end
            S_R_HI:    state_n = S_R_LO;
            S_R_LO:    state_n = S_W_CLR;
            S_W_CLR:   state_n = S_W_UNCLR;
            S_W_UNCLR: state_n = S_RESP;
            S_RESP:    if (bus.rsp_ready) state_n = S_IDLE;
            default:   state_n = S_IDLE;
        endcase

        // Bus fields are registered, so they are decoded from the next state.
        sel_n  = 1'b0;
        wr_n   = 1'b0;
        addr_n = '0;
        dout_n = '0;
        case (state_n)
            S_W_IEN: begin
                sel_n = 1'b1; wr_n = 1'b1;
                addr_n = ADDR_INTREN;
                dout_n = {63'b0, USE_IRQ};
            end
            S_W_OPND: begin
                sel_n = 1'b1; wr_n = 1'b1;
                addr_n = ADDR_OPERAND;
                dout_n = operand;
            end
            S_W_STRT: begin
                sel_n = 1'b1; wr_n = 1'b1;
                addr_n = ADDR_OPSTART;
                dout_n = 64'd1;
            end
            S_W_UNST: begin
                sel_n = 1'b1; wr_n = 1'b1;
                addr_n = ADDR_OPSTART;
            end
            S_WAIT: begin
                if (!USE_IRQ && gap_n == 16'd0) begin
                    sel_n  = 1'b1;
                    addr_n = ADDR_OPDONE;
                end
            end
            S_R_HI: begin
                sel_n = 1'b1;
                addr_n = ADDR_RESULT_H;
            end
            S_R_LO: begin
                sel_n = 1'b1;
                addr_n = ADDR_RESULT_L;
            end
            S_W_CLR: begin
                sel_n = 1'b1; wr_n = 1'b1;
                addr_n = ADDR_OPCLEAR;
                dout_n = 64'd1;
            end
            S_W_UNCLR: begin
                sel_n = 1'b1; wr_n = 1'b1;
                addr_n = ADDR_OPCLEAR;
            end
            default: ;
        endcase
    end

    assign bus.cmd_ready   = (state == S_IDLE);
    assign bus.busy        = (state != S_IDLE);
    assign bus.rsp_valid   = (state == S_RESP);
    assign bus.rsp_result  = result;
    assign bus.rsp_timeout = timeout_q;
    assign bus.m_sel       = sel_q;
    assign bus.m_wr        = wr_q;
    assign bus.m_addr      = addr_q;
    assign bus.m_dout      = dout_q;

endmodule

// File: tb/tb_facto_bus_master.sv
// Directed bench: interrupt-driven master (a_*) and polling master (p_*),
// each attached to a small behavioural factorial-core slave.
module tb_facto_bus_master;

    localparam int LAT = 10;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    always #5 clk = ~clk;

    facto_bus_master_if bi ();
    facto_bus_master_if bp ();

    facto_bus_master #(.USE_IRQ(1'b1), .TIMEOUT(100)) dut_irq (
        .clk(clk), .reset(reset), .bus(bi)
    );

    facto_bus_master #(.USE_IRQ(1'b0), .POLL_GAP(2), .TIMEOUT(100)) dut_poll (
        .clk(clk), .reset(reset), .bus(bp)
    );

    function automatic logic [127:0] fact(input logic [63:0] n);
        logic [127:0] r;
        r = 128'd1;
        for (longint k = 2; k <= longint'(n); k++)
            r = r * 128'(k);
        return r;
    endfunction

    function automatic logic [63:0] rdmux(input logic [15:0] a, input logic ien,
                                          input logic [63:0] opnd, input logic dn,
                                          input logic [127:0] res);
        case (a)
            16'h0010: return {63'b0, dn};
            16'h0018: return {63'b0, ien};
            16'h0020: return opnd;
            16'h0028: return res[127:64];
            16'h0030: return res[63:0];
            default:  return 64'd0;
        endcase
    endfunction

    logic         a_ien, a_done, a_hang;
    logic [63:0]  a_opnd;
    logic [127:0] a_res;
    int           a_cnt;
    logic         p_ien, p_done;
    logic [63:0]  p_opnd;
    logic [127:0] p_res;
    int           p_cnt;

    always @(posedge clk) begin
        if (reset) begin
            a_ien <= 0; a_done <= 0; a_opnd <= 0; a_res <= 0; a_cnt <= 0;
        end else begin
            if (a_cnt != 0) begin
                a_cnt <= a_cnt - 1;
                if (a_cnt == 1 && !a_hang) begin
                    a_done <= 1'b1;
                    a_res  <= fact(a_opnd);
                end
            end
            if (bi.m_sel && bi.m_wr) begin
                if (bi.m_addr == 16'h0018) a_ien <= bi.m_dout[0];
                if (bi.m_addr == 16'h0020) a_opnd <= bi.m_dout;
                if (bi.m_addr == 16'h0000 && bi.m_dout[0]) a_cnt <= LAT;
                if (bi.m_addr == 16'h0008 && bi.m_dout[0]) a_done <= 1'b0;
            end
        end
    end

    always @(posedge clk) begin
        if (reset) begin
            p_ien <= 0; p_done <= 0; p_opnd <= 0; p_res <= 0; p_cnt <= 0;
        end else begin
            if (p_cnt != 0) begin
                p_cnt <= p_cnt - 1;
                if (p_cnt == 1) begin
                    p_done <= 1'b1;
                    p_res  <= fact(p_opnd);
                end
            end
            if (bp.m_sel && bp.m_wr) begin
                if (bp.m_addr == 16'h0018) p_ien <= bp.m_dout[0];
                if (bp.m_addr == 16'h0020) p_opnd <= bp.m_dout;
                if (bp.m_addr == 16'h0000 && bp.m_dout[0]) p_cnt <= LAT;
                if (bp.m_addr == 16'h0008 && bp.m_dout[0]) p_done <= 1'b0;
            end
        end
    end

    assign bi.m_din     = rdmux(bi.m_addr, a_ien, a_opnd, a_done, a_res);
    assign bi.interrupt = a_done & a_ien;
    assign bp.m_din     = rdmux(bp.m_addr, p_ien, p_opnd, p_done, p_res);
    assign bp.interrupt = p_done & p_ien;

    logic [80:0] a_log[$];
    int          p_polls[$];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bi.m_sel)
            a_log.push_back({bi.m_wr, bi.m_addr, bi.m_wr ? bi.m_dout : 64'd0});
        if (bp.m_sel && !bp.m_wr && bp.m_addr == 16'h0010)
            p_polls.push_back(cyc);
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_for(input int what, input int lim, input string tag);
        logic hit;
        hit = 1'b0;
        for (int k = 0; k < lim && !hit; k++) begin
            @(negedge clk);
            case (what)
                0:       hit = bi.cmd_ready;
                1:       hit = bi.rsp_valid;
                default: hit = bp.rsp_valid;
            endcase
        end
        chk(tag, hit, 1);
    endtask

    logic [80:0]  exp2 [8];
    logic [127:0] r1, r2;
    logic         ok;
    int           base, n;

    initial begin
        exp2 = '{{1'b1, 16'h0018, 64'd1}, {1'b1, 16'h0020, 64'd5},
                 {1'b1, 16'h0000, 64'd1}, {1'b1, 16'h0000, 64'd0},
                 {1'b0, 16'h0028, 64'd0}, {1'b0, 16'h0030, 64'd0},
                 {1'b1, 16'h0008, 64'd1}, {1'b1, 16'h0008, 64'd0}};
        a_hang = 1'b0;
        bi.cmd_valid = 0; bi.cmd_operand = 0; bi.rsp_ready = 0;
        bp.cmd_valid = 0; bp.cmd_operand = 0; bp.rsp_ready = 0;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        chk("rst_ready", bi.cmd_ready, 1);
        chk("rst_busy", bi.busy, 0);
        chk("rst_rsp_valid", bi.rsp_valid, 0);
        chk("rst_sel", bi.m_sel, 0);
        chk("rst_result", bi.rsp_result, 0);
        chk("rst_timeout", bi.rsp_timeout, 0);

        // irq mode, operand 5: exact bus sequence
        base = a_log.size();
        bi.cmd_valid = 1; bi.cmd_operand = 64'd5;
        @(negedge clk);
        bi.cmd_valid = 0;
        chk("acc_busy", bi.busy, 1);
        chk("acc_ready", bi.cmd_ready, 0);
        chk("ien_addr", {bi.m_sel, bi.m_wr, bi.m_addr}, {2'b11, 16'h0018});
        wait_for(1, 200, "wait_rsp5");
        chk("res5", bi.rsp_result, 128'd120);
        chk("res5_to", bi.rsp_timeout, 0);
        chk("log5_len", a_log.size() - base, 8);
        for (int i = 0; i < 8; i++)
            chk($sformatf("log5_%0d", i), a_log[base + i], exp2[i]);

        // response held off while a new command waits
        base = a_log.size();
        bi.cmd_valid = 1; bi.cmd_operand = 64'd3;
        ok = 1'b1;
        repeat (10) begin
            @(negedge clk);
            ok &= bi.rsp_valid && bi.rsp_result == 128'd120 && !bi.cmd_ready;
        end
        chk("hold_stable", ok, 1);
        chk("hold_nobus", a_log.size() - base, 0);

        // back-to-back 3 then 4
        bi.rsp_ready = 1;
        wait_for(0, 20, "b2b_idle1");
        @(negedge clk);
        bi.cmd_operand = 64'd4;
        wait_for(1, 200, "b2b_rsp1");
        r1 = bi.rsp_result;
        wait_for(0, 20, "b2b_idle2");
        @(negedge clk);
        bi.cmd_valid = 0;
        wait_for(1, 200, "b2b_rsp2");
        r2 = bi.rsp_result;
        chk("b2b_res3", r1, 128'd6);
        chk("b2b_res4", r2, 128'd24);
        repeat (5) @(negedge clk);
        chk("b2b_idle", bi.busy, 0);
        bi.rsp_ready = 0;

        // slave never completes -> timeout
        a_hang = 1'b1;
        base = a_log.size();
        bi.cmd_valid = 1; bi.cmd_operand = 64'd7;
        @(negedge clk);
        bi.cmd_valid = 0;
        wait_for(1, 400, "wait_to");
        chk("to_flag", bi.rsp_timeout, 1);
        chk("to_result", bi.rsp_result, 0);
        ok = 1'b0;
        n = 0;
        for (int i = base; i < a_log.size(); i++) begin
            if (a_log[i] == {1'b1, 16'h0008, 64'd1}) ok = 1'b1;
            if (a_log[i][79:64] == 16'h0028) n++;
        end
        chk("to_clear", ok, 1);
        chk("to_noread", n, 0);
        bi.rsp_ready = 1;
        @(negedge clk);
        bi.rsp_ready = 0;
        a_hang = 1'b0;

        // next command clears timeout
        bi.cmd_valid = 1; bi.cmd_operand = 64'd2;
        @(negedge clk);
        bi.cmd_valid = 0;
        chk("to_cleared", bi.rsp_timeout, 0);
        wait_for(1, 200, "wait_rsp2");
        chk("res2", bi.rsp_result, 128'd2);
        bi.rsp_ready = 1;
        @(negedge clk);
        bi.rsp_ready = 0;

        // reset in the middle of WAIT
        a_hang = 1'b1;
        bi.cmd_valid = 1; bi.cmd_operand = 64'd9;
        @(negedge clk);
        bi.cmd_valid = 0;
        repeat (8) @(negedge clk);
        chk("mid_busy", bi.busy, 1);
        chk("mid_sel", bi.m_sel, 0);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        a_hang = 1'b0;
        chk("mr_ready", bi.cmd_ready, 1);
        chk("mr_busy", bi.busy, 0);
        chk("mr_bus", {bi.m_sel, bi.m_wr, bi.m_addr, bi.m_dout}, 0);
        chk("mr_rsp", {bi.rsp_valid, bi.rsp_timeout}, 0);
        chk("mr_result", bi.rsp_result, 0);

        // polling mode, operand 20
        base = p_polls.size();
        bp.cmd_valid = 1; bp.cmd_operand = 64'd20;
        @(negedge clk);
        bp.cmd_valid = 0;
        wait_for(2, 400, "wait_poll");
        chk("poll_res", bp.rsp_result, 128'h21C3677C82B40000);
        chk("poll_to", bp.rsp_timeout, 0);
        n = p_polls.size() - base;
        chk("poll_count", n >= 2, 1);
        ok = 1'b1;
        for (int i = base + 1; i < p_polls.size(); i++)
            if (p_polls[i] - p_polls[i - 1] != 3) ok = 1'b0;
        chk("poll_gap", ok, 1);
        bp.rsp_ready = 1;
        @(negedge clk);
        bp.rsp_ready = 0;
        @(negedge clk);
        chk("poll_idle", bp.cmd_ready, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
